keypad_scan: RTL



---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_debounce.sv | 113 +++++++++++
 rtl/keypad_scan.sv | 97 +++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, debounce state type and column-decode helper for the keypad scanner.
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int KEY_W    = 4;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_CHECK,
      PRESSED,
      RELEASE_CHECK
   } deb_state_t;

   // Row 0 driven low out of reset
   localparam logic [NUM_ROWS-1:0] ROW_RESET = 4'b1110;

   // Index of the lowest-numbered active-low column; caller checks that one is active
   function automatic logic [1:0] first_low_col(input logic [NUM_COLS-1:0] cols);
      logic [1:0] idx;
      idx = 2'd0;
      for (int c = NUM_COLS - 1; c >= 0; c--) begin
         if (!cols[c]) idx = 2'(c);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounces whole-scan results into a one-clock press strobe plus a held flag.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             scan_done,
   input  logic             found,
   input  logic [KEY_W-1:0] code,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             key_held
);

   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   deb_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;
   logic [KEY_W-1:0] cand_q;

   // Saturating increment so the counter never wraps
   always_comb begin
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
   end

   // Debounce FSM; advances only on the end-of-scan strobe, outputs are registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RELEASED;
         cnt_q     <= '0;
         cand_q    <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (scan_done) begin
            unique case (state_q)
               RELEASED: begin
                  if (found) begin
                     if (DEBOUNCE_SCANS == 1) begin
                        key_code  <= code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= PRESSED;
                     end else begin
                        cand_q  <= code;
                        cnt_q   <= CNT_ONE;
                        state_q <= PRESS_CHECK;
                     end
                  end
               end
               PRESS_CHECK: begin
                  if (found && code == cand_q) begin
                     if (cnt_inc == CNT_MAX) begin
                        key_code  <= cand_q;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= PRESSED;
                     end else begin
                        cnt_q <= cnt_inc;
                     end
                  end else if (found) begin
                     // A different key restarts the press qualification
                     cand_q <= code;
                     cnt_q  <= CNT_ONE;
                  end else begin
                     cnt_q   <= '0;
                     state_q <= RELEASED;
                  end
               end
               PRESSED: begin
                  if (!(found && code == key_code)) begin
                     if (DEBOUNCE_SCANS == 1) begin
                        key_held <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= RELEASED;
                     end else begin
                        cnt_q   <= CNT_ONE;
                        state_q <= RELEASE_CHECK;
                     end
                  end
               end
               RELEASE_CHECK: begin
                  if (found && code == key_code) begin
                     cnt_q   <= '0;
                     state_q <= PRESSED;
                  end else if (cnt_inc == CNT_MAX) begin
                     // Any other key counts only toward release
                     key_held <= 1'b0;
                     cnt_q    <= '0;
                     state_q  <= RELEASED;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
               default: begin
                  cnt_q   <= '0;
                  state_q <= RELEASED;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad row scanner: column synchroniser, row/settle counters,
// per-scan accumulator, and the debouncer that produces key events.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SETTLE_TICKS   = 4,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                scan_tick,
   input  logic [NUM_COLS-1:0] COLUMN,
   output logic [NUM_ROWS-1:0] ROW,
   output logic [KEY_W-1:0]    key_code,
   output logic                key_valid,
   output logic                key_held
);

   localparam int TICK_W = $clog2(SETTLE_TICKS);
   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(SETTLE_TICKS - 1);

   logic [NUM_COLS-1:0] col_meta_q;
   logic [NUM_COLS-1:0] col_sync_q;
   logic [TICK_W-1:0]   tick_q;
   logic [1:0]          row_idx_q;
   logic [1:0]          row_idx_nxt;
   logic                sample;
   logic                found_q;
   logic [KEY_W-1:0]    code_q;
   logic                scan_done_q;

   // Sample strobe on the last settle tick of the current row
   always_comb begin
      sample      = scan_tick && (tick_q == LAST_TICK);
      row_idx_nxt = row_idx_q + 2'd1;
   end

   // Two-flop synchroniser for the asynchronous column lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta_q <= '1;
         col_sync_q <= '1;
      end else begin
         col_meta_q <= COLUMN;
         col_sync_q <= col_meta_q;
      end
   end

   // Settle-tick counter and row advance; ROW changes in the same clk as the index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q    <= '0;
         row_idx_q <= '0;
         ROW       <= ROW_RESET;
      end else if (scan_tick) begin
         if (sample) begin
            tick_q    <= '0;
            row_idx_q <= row_idx_nxt;
            ROW       <= ~(4'b0001 << row_idx_nxt);
         end else begin
            tick_q <= tick_q + TICK_W'(1);
         end
      end
   end

   // Accumulate the first active key of the scan; cleared once the debouncer has seen it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         found_q     <= 1'b0;
         code_q      <= '0;
         scan_done_q <= 1'b0;
      end else begin
         scan_done_q <= sample && (row_idx_q == 2'd3);
         if (scan_done_q) begin
            found_q <= 1'b0;
            code_q  <= '0;
         end else if (sample && !found_q && (col_sync_q != '1)) begin
            found_q <= 1'b1;
            code_q  <= {row_idx_q, first_low_col(col_sync_q)};
         end
      end
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .scan_done (scan_done_q),
      .found     (found_q),
      .code      (code_q),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

endmodule
